spi_crc_master: RTL and testbench

SPI initiator that drives the CRC-protected 24+8-bit frame used by the team's SPI slave. It sits on the system clock domain, generates `sck`/`csn`/`mosi` from a parallel request, and captures the slave's `miso` stream into a parallel word with a CRC verdict. The slave transmits on the `sck` rising edge and samples on the falling edge. This master matches that: it launches `mosi` with `sck` rising and samples `miso` with `sck` falling.

---
 rtl/spi_crc_master.sv | 210 +++++++++++++++++++++
 tb/tb_spi_crc_master.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_crc_master.sv
// SPI initiator for the 24-bit payload + CRC-8 trailer frame (mosi launched on sck rise, miso sampled on sck fall).
// Define SPI_MASTER_CRC_EN for the 32-bit frame with CRC; undefined gives a plain 24-bit frame.
module spi_crc_master #(
    parameter int unsigned CLK_DIV  = 4
`ifdef SPI_MASTER_CRC_EN
    ,
    parameter logic [7:0]  CRC_POLY = 8'h1D,
    parameter logic [7:0]  CRC_INIT = 8'hFF
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] tx_data,
    output logic        busy,
    output logic        done,
    output logic [23:0] rx_data,
    output logic [7:0]  rx_crc,
    output logic        crc_err,
    output logic        sck,
    output logic        csn,
    output logic        mosi,
    input  logic        miso
);

`ifdef SPI_MASTER_CRC_EN
    localparam int unsigned NBITS = 32;
`else
    localparam int unsigned NBITS = 24;
`endif
    localparam int unsigned   DW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_RELOAD = DW'(CLK_DIV - 1);
    localparam logic [5:0]    LAST_BIT   = 6'(NBITS - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t             state_q, state_d;
    logic [DW-1:0]      div_q, div_d;
    logic [5:0]         bit_q, bit_d;
    logic               sck_q, sck_d;
    logic               csn_q, csn_d;
    logic               mosi_q, mosi_d;
    logic               done_q, done_d;
    logic [22:0]        tx_sh_q, tx_sh_d;
    logic [NBITS-1:0]   rx_sh_q, rx_sh_d;
    logic [23:0]        rx_data_q, rx_data_d;
    logic               tick;

`ifdef SPI_MASTER_CRC_EN
    logic [7:0] tx_crc_q, tx_crc_d;
    logic [7:0] rx_calc_q, rx_calc_d;
    logic [7:0] rx_crc_q, rx_crc_d;
    logic       crc_err_q, crc_err_d;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? CRC_POLY : 8'h00);
    endfunction
`endif

    assign tick = (div_q == '0);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        sck_d     = sck_q;
        csn_d     = csn_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
`ifdef SPI_MASTER_CRC_EN
        tx_crc_d  = tx_crc_q;
        rx_calc_d = rx_calc_q;
        rx_crc_d  = rx_crc_q;
        crc_err_d = crc_err_q;
`endif

        if (state_q != IDLE) begin
            div_d = tick ? DIV_RELOAD : div_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    div_d   = DIV_RELOAD;
                    bit_d   = '0;
                    csn_d   = 1'b0;
                    mosi_d  = tx_data[23];
                    tx_sh_d = tx_data[22:0];
`ifdef SPI_MASTER_CRC_EN
                    tx_crc_d  = CRC_INIT;
                    rx_calc_d = CRC_INIT;
`endif
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = SHIFT;
                    sck_d   = 1'b1;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (sck_q) begin
                        sck_d   = 1'b0;
                        rx_sh_d = {rx_sh_q[NBITS-2:0], miso};
                        bit_d   = bit_q + 6'd1;
`ifdef SPI_MASTER_CRC_EN
                        // Both CRCs advance on the fall so mosi_q still holds the bit just sent
                        if (bit_q < 6'd24) begin
                            tx_crc_d  = crc8_step(tx_crc_q, mosi_q);
                            rx_calc_d = crc8_step(rx_calc_q, miso);
                        end
`endif
                        if (bit_q == LAST_BIT) begin
                            state_d = HOLD;
                        end
                    end else begin
                        sck_d = 1'b1;
`ifdef SPI_MASTER_CRC_EN
                        if (bit_q >= 6'd24) begin
                            mosi_d   = tx_crc_q[7];
                            tx_crc_d = {tx_crc_q[6:0], 1'b0};
                        end else
`endif
                        begin
                            mosi_d  = tx_sh_q[22];
                            tx_sh_d = {tx_sh_q[21:0], 1'b0};
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d   = GAP;
                    csn_d     = 1'b1;
                    mosi_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_sh_q[NBITS-1 -: 24];
`ifdef SPI_MASTER_CRC_EN
                    rx_crc_d  = rx_sh_q[7:0];
                    crc_err_d = (rx_calc_q != rx_sh_q[7:0]);
`endif
                end
            end
            GAP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            sck_q     <= 1'b0;
            csn_q     <= 1'b1;
            mosi_q    <= 1'b0;
            done_q    <= 1'b0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
`ifdef SPI_MASTER_CRC_EN
            tx_crc_q  <= '0;
            rx_calc_q <= '0;
            rx_crc_q  <= '0;
            crc_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            sck_q     <= sck_d;
            csn_q     <= csn_d;
            mosi_q    <= mosi_d;
            done_q    <= done_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
`ifdef SPI_MASTER_CRC_EN
            tx_crc_q  <= tx_crc_d;
            rx_calc_q <= rx_calc_d;
            rx_crc_q  <= rx_crc_d;
            crc_err_q <= crc_err_d;
`endif
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign sck     = sck_q;
    assign csn     = csn_q;
    assign mosi    = mosi_q;
    assign rx_data = rx_data_q;
`ifdef SPI_MASTER_CRC_EN
    assign rx_crc  = rx_crc_q;
    assign crc_err = crc_err_q;
`else
    assign rx_crc  = '0;
    assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_crc_master.sv
// Bench for spi_crc_master: table of frames with a result scoreboard, plus start-probe and reset-abort sequences.
module tb_spi_crc_master;

`ifdef SPI_MASTER_CRC_EN
    localparam int unsigned DIV    = 2;
    localparam int unsigned NB     = 32;
    localparam bit          CRC_ON = 1'b1;
`else
    localparam int unsigned DIV    = 3;
    localparam int unsigned NB     = 24;
    localparam bit          CRC_ON = 1'b0;
`endif
    localparam int unsigned T_DONE = (2 * NB + 1) * DIV;
    localparam int unsigned T_FREE = (2 * NB + 2) * DIV;
    localparam int unsigned NVEC   = 5;

    typedef struct {
        logic [23:0] txd;
        bit          loopback;
        logic [31:0] miso_pat;
        logic [7:0]  exp_trailer;
        logic [23:0] exp_rxd;
        logic [7:0]  exp_rxc;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [23:0] rxd;
        logic [7:0]  rxc;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] tx_data = '0;
    logic        miso = 1'b0;
    logic        busy, done, crc_err, sck, csn, mosi;
    logic [23:0] rx_data;
    logic [7:0]  rx_crc;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [23:0] held_rxd = '0;
    exp_t        sb_q[$];
    vec_t        vecs[NVEC];

    always #5 clk = ~clk;

    spi_crc_master #(.CLK_DIV(DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .tx_data (tx_data),
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data),
        .rx_crc  (rx_crc),
        .crc_err (crc_err),
        .sck     (sck),
        .csn     (csn),
        .mosi    (mosi),
        .miso    (miso)
    );

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] crc_model(input logic [23:0] d);
        logic [7:0] c;
        c = 8'hFF;
        for (int i = 23; i >= 0; i--) begin
            if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h1D;
            else             c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input vec_t v, input bit probe_start);
        int unsigned rel, k, bad_time, bad_stab, done_cnt, sck_csn_bad, pulses;
        logic [31:0] stream, mask, exp_stream;
        logic        prev_sck, prev_mosi, rise;
        bit          finished;
        exp_t        e;

        e.rxd = v.exp_rxd;
        e.rxc = v.exp_rxc & {8{CRC_ON}};
        e.err = v.exp_err & CRC_ON;
        sb_q.push_back(e);

        miso    = 1'b0;
        tx_data = v.txd;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        tx_data = ~v.txd;
        chk("accept_busy", 32'(busy), 32'(1));
        chk("accept_csn", 32'(csn), 32'(0));
        chk("accept_sck", 32'(sck), 32'(0));
        chk("accept_mosi", 32'(mosi), 32'(v.txd[23]));

        rel = 0; k = 0; bad_time = 0; bad_stab = 0; done_cnt = 0; sck_csn_bad = 0; pulses = 0;
        stream = '0; prev_sck = sck; prev_mosi = mosi; finished = 0;
        while (!finished && rel < T_FREE + 20) begin
            if (probe_start && (rel == 10 || rel == T_FREE - 1)) start = 1'b1;
            tick();
            rel++;
            start = 1'b0;
            if (sck && csn) sck_csn_bad++;
            rise = sck && !prev_sck;
            if (mosi !== prev_mosi && !rise && !done) bad_stab++;
            if (rise) begin
                pulses++;
                if (rel != (2 * k + 1) * DIV) bad_time++;
                if (k < 32) begin
                    stream[31 - k] = mosi;
                    miso = v.loopback ? mosi : v.miso_pat[31 - k];
                end
            end else if (!sck && prev_sck) begin
                if (rel != (2 * k + 2) * DIV) bad_time++;
                k++;
            end
            prev_sck  = sck;
            prev_mosi = mosi;
            if (rel == T_DONE - 1) chk("rx_hold", 32'(rx_data), 32'(held_rxd));
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    chk("done_time", rel, T_DONE);
                    chk("done_csn", 32'(csn), 32'(1));
                    chk("done_mosi", 32'(mosi), 32'(0));
                    if (sb_q.size() == 0) begin
                        chk("scoreboard_underflow", 32'(1), 32'(0));
                    end else begin
                        e = sb_q.pop_front();
                        chk("rx_data", 32'(rx_data), 32'(e.rxd));
                        chk("rx_crc", 32'(rx_crc), 32'(e.rxc));
                        chk("crc_err", 32'(crc_err), 32'(e.err));
                        held_rxd = e.rxd;
                    end
                end
            end
            if (!busy) begin
                chk("busy_fall_time", rel, T_FREE);
                finished = 1;
            end
        end
        if (!finished) chk("frame_timeout", rel, T_FREE);
        mask       = CRC_ON ? 32'hFFFF_FFFF : 32'hFFFF_FF00;
        exp_stream = {v.txd, v.exp_trailer};
        chk("mosi_stream", stream & mask, exp_stream & mask);
        chk("sck_pulses", pulses, NB);
        chk("sck_edge_timing", bad_time, 0);
        chk("mosi_stable", bad_stab, 0);
        chk("sck_high_csn_high", sck_csn_bad, 0);
        chk("done_width", done_cnt, 1);
    endtask

    initial begin
        int unsigned idle_bad, guard, abort_bad;

        vecs[0] = '{24'h000000, 1'b0, 32'h0000_0000, 8'h0E, 24'h000000, 8'h00, 1'b1};
        vecs[1] = '{24'hA5C33C, 1'b1, 32'h0000_0000, crc_model(24'hA5C33C),
                    24'hA5C33C, crc_model(24'hA5C33C), 1'b0};
        vecs[2] = '{24'h5A5A5A, 1'b0, 32'h0000_000E, crc_model(24'h5A5A5A), 24'h000000, 8'h0E, 1'b0};
        vecs[3] = '{24'hFFFFFF, 1'b0, {24'hC0FFEE, crc_model(24'hC0FFEE)}, crc_model(24'hFFFFFF),
                    24'hC0FFEE, crc_model(24'hC0FFEE), 1'b0};
        vecs[4] = '{24'h800001, 1'b0, {24'h123456, crc_model(24'h123456) ^ 8'h01}, crc_model(24'h800001),
                    24'h123456, crc_model(24'h123456) ^ 8'h01, 1'b1};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_sck", 32'(sck), 32'(0));
        chk("rst_csn", 32'(csn), 32'(1));
        chk("rst_mosi", 32'(mosi), 32'(0));
        chk("rst_rx_data", 32'(rx_data), 32'(0));
        chk("rst_rx_crc", 32'(rx_crc), 32'(0));
        chk("rst_crc_err", 32'(crc_err), 32'(0));
        rst = 1'b0;
        idle_bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (sck !== 1'b0 || csn !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idle_bad++;
        end
        chk("idle_hold", idle_bad, 0);

        for (int i = 0; i < NVEC; i++) run_frame(vecs[i], 1'b0);

        // Starts at T0+10 and T0+(2N+2)D-1 must be dropped; the one right after busy falls is taken.
        run_frame(vecs[1], 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_busy", 32'(busy), 32'(1));
        chk("restart_csn", 32'(csn), 32'(0));

        repeat (40) tick();
        guard = 0;
        while (!sck && guard < 4 * DIV) begin
            tick();
            guard++;
        end
        chk("abort_sck_high", 32'(sck), 32'(1));
        rst = 1'b1;
        #1;
        chk("abort_csn", 32'(csn), 32'(1));
        chk("abort_sck", 32'(sck), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_mosi", 32'(mosi), 32'(0));
        chk("abort_rx_data", 32'(rx_data), 32'(0));
        tick();
        rst = 1'b0;
        held_rxd = '0;
        abort_bad = 0;
        for (int i = 0; i < int'(T_FREE) + 10; i++) begin
            tick();
            if (done || busy || !csn) abort_bad++;
        end
        chk("abort_no_done", abort_bad, 0);

        run_frame(vecs[3], 1'b0);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
